// File: rtl/button_ctrl.sv
// button_ctrl: debounced push-button / LED controller with a Wishbone register file.
//
// Optional feature macro: BUTTON_CTRL_IRQ_EN
//   defined   -> IRQ_EN register at 0xC, irq_o = registered OR(PRESS & IRQ_EN)
//   undefined -> no IRQ_EN register, 0xC reads 0, irq_o tied 0
//
// Ports:
//   wb_clk_i             clock, all state on rising edge
//   wb_rst_ni            asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i Wishbone strobe, cycle, write enable
//   wbs_sel_i            byte selects (only bit 0 gates writes)
//   wbs_dat_i/adr_i      write data and address (decoded on adr[3:2])
//   wbs_ack_o            single-cycle acknowledge
//   wbs_dat_o            read data, valid only in the ack cycle
//   btn_i                raw active-high buttons, asynchronous
//   led_o                LED drive
//   led_oeb_o            output enables, always driving (0)
//   irq_o                level interrupt
//
// Register map: 0x0 STATUS (db, RO), 0x4 MODE (RW), 0x8 PRESS (W1C), 0xC IRQ_EN (RW)
module button_ctrl #(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = 1000
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_dat_i,
    input  logic [31:0]     wbs_adr_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] led_o,
    output logic [N_CH-1:0] led_oeb_o,
    output logic            irq_o
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [N_CH-1:0] sync1, sync2, db, diff, hit, rise;
    logic [CW-1:0]   cnt      [N_CH];
    logic [CW-1:0]   cnt_next [N_CH];
    logic [N_CH-1:0] mode, mode_next, mode_rise, press, w1c, tog, tog_next, led_next;
    logic [N_CH-1:0] ien_val, rd_reg, wr_data;
    logic [1:0]      reg_sel;
    logic            req, wr;
    logic [31:0]     rdata;
    logic            unused;

    assign unused    = ^{wbs_sel_i[3:1], wbs_dat_i[31:N_CH], wbs_adr_i[31:4], wbs_adr_i[1:0]};
    assign led_oeb_o = '0;

    // Debounce: count consecutive mismatching cycles; the last one flips db and clears.
    assign diff = sync2 ^ db;
    assign rise = hit & sync2;

    always_comb begin
        hit = '0;
        for (int i = 0; i < N_CH; i++) begin
            hit[i]      = diff[i] && (cnt[i] == CNT_LAST);
            cnt_next[i] = (diff[i] && !hit[i]) ? cnt[i] + CW'(1) : '0;
        end
    end

    // A request is accepted only while ack is low, so acks never come back to back.
    assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr      = req & wbs_we_i & wbs_sel_i[0];
    assign reg_sel = wbs_adr_i[3:2];
    assign wr_data = wbs_dat_i[N_CH-1:0];

    assign mode_next = (wr && reg_sel == 2'd1) ? wr_data : mode;
    assign mode_rise = mode_next & ~mode;
    assign w1c       = (wr && reg_sel == 2'd2) ? wr_data : '0;

    // Entering toggle mode seeds the toggle state with the visible LED so it does not jump.
    assign tog_next = (mode_rise & led_o) | (~mode_rise & (tog ^ rise));
    assign led_next = (mode & tog) | (~mode & db);

    always_comb begin
        rd_reg = (reg_sel == 2'd0) ? db :
                 (reg_sel == 2'd1) ? mode :
                 (reg_sel == 2'd2) ? press : ien_val;
        rdata  = {{(32 - N_CH){1'b0}}, rd_reg};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sync1     <= '0;
            sync2     <= '0;
            db        <= '0;
            cnt       <= '{default: '0};
            mode      <= '0;
            press     <= '0;
            tog       <= '0;
            led_o     <= '0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            sync1     <= btn_i;
            sync2     <= sync1;
            db        <= db ^ hit;
            cnt       <= cnt_next;
            mode      <= mode_next;
            press     <= (press & ~w1c) | rise;
            tog       <= tog_next;
            led_o     <= led_next;
            wbs_ack_o <= req;
            wbs_dat_o <= (req && !wbs_we_i) ? rdata : '0;
        end
    end

`ifdef BUTTON_CTRL_IRQ_EN
    logic [N_CH-1:0] irq_en;

    assign ien_val = irq_en;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            irq_en <= '0;
            irq_o  <= 1'b0;
        end else begin
            irq_en <= (wr && reg_sel == 2'd3) ? wr_data : irq_en;
            irq_o  <= |(press & irq_en);
        end
    end
`else
    assign ien_val = '0;
    assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed and randomized checks of button_ctrl against a behavioural model.
module tb_button_ctrl;
    localparam int N  = 4;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc_i = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] wdat = '0, adr = '0;
    logic [3:0]  btn = 4'h0;
    logic        ack, irq;
    logic [31:0] rdat;
    logic [3:0]  led, oeb;

    int checks = 0;
    int errors = 0;

    // Model: synchronized samples, debounced levels, mismatch streak lengths, and for
    // toggle mode the LED value at mode entry plus parity of presses since then.
    logic [3:0]  m_s1, m_s2, m_db, m_press, m_mode, m_base, m_par, m_led, m_ien;
    logic        m_ack, m_irq;
    logic [31:0] m_dat;
    int          streak [N];

    button_ctrl #(.N_CH(N), .DB_CYCLES(DB)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_i), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .btn_i(btn), .led_o(led), .led_oeb_o(oeb), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        {m_s1, m_s2, m_db, m_press, m_mode, m_base, m_par, m_led, m_ien} = '0;
        m_ack = 1'b0;
        m_irq = 1'b0;
        m_dat = '0;
        for (int i = 0; i < N; i++) streak[i] = 0;
    endtask

    task automatic step();
        logic [3:0]  o_s2, o_db, o_press, o_mode, o_led, o_base, o_par, o_ien, rise, w, nm, ent, b;
        logic        req, wr;
        logic [1:0]  a;
        logic [31:0] rd;
        b = btn;
        req = stb & cyc_i & ~m_ack;
        wr = req & we & sel[0];
        a = adr[3:2];
        w = wdat[3:0];
        o_s2 = m_s2; o_db = m_db; o_press = m_press; o_mode = m_mode;
        o_led = m_led; o_base = m_base; o_par = m_par; o_ien = m_ien;
        rd = {28'd0, (a == 2'd0) ? m_db : (a == 2'd1) ? m_mode : (a == 2'd2) ? m_press : m_ien};
        @(posedge clk);
        if (rst_n) begin
            rise = '0;
            for (int i = 0; i < N; i++) begin
                if (o_s2[i] != o_db[i]) begin
                    streak[i]++;
                    if (streak[i] == DB) begin
                        m_db[i] = o_s2[i];
                        rise[i] = o_s2[i];
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
                m_led[i] = o_mode[i] ? (o_base[i] ^ o_par[i]) : o_db[i];
            end
            m_s2 = m_s1;
            m_s1 = b;
            m_press = (o_press & ~((wr && a == 2'd2) ? w : 4'h0)) | rise;
            nm = (wr && a == 2'd1) ? w : o_mode;
            ent = nm & ~o_mode;
            m_base = (ent & o_led) | (~ent & o_base);
            m_par = (o_par ^ rise) & ~ent;
            m_mode = nm;
`ifdef BUTTON_CTRL_IRQ_EN
            m_irq = |(o_press & o_ien);
            if (wr && a == 2'd3) m_ien = w;
`endif
            m_ack = req;
            m_dat = (req && !we) ? rd : 32'd0;
        end
        #1;
        chk("led", {28'd0, led}, {28'd0, m_led});
        chk("ack", {31'd0, ack}, {31'd0, m_ack});
        chk("dat", rdat, m_dat);
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        chk("oeb", {28'd0, oeb}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        adr = a; wdat = d; sel = 4'h1; we = 1'b1; stb = 1'b1; cyc_i = 1'b1;
        step();
        chk("wr_ack", {31'd0, ack}, 32'd1);
        stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
        step();
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        adr = a; we = 1'b0; sel = 4'hF; stb = 1'b1; cyc_i = 1'b1;
        step();
        chk("rd_ack", {31'd0, ack}, 32'd1);
        d = rdat;
        stb = 1'b0; cyc_i = 1'b0;
        step();
        chk("rd_ack_drop", {31'd0, ack}, 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
        model_reset();
        btn = 4'b0001;
        idle(3);
        chk("reset_led", {28'd0, led}, 32'd0);
        chk("reset_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        idle(6);
        chk("held_led_lag", {28'd0, led}, 32'd0);
        step();
        chk("held_led", {28'd0, led}, 32'h1);
        wb_read(32'h0, d);
        chk("held_status", d, 32'h1);
        wb_read(32'h8, d);
        chk("held_press", d, 32'h1);

        wb_write(32'h8, 32'hF);
        wb_read(32'h8, d);
        chk("w1c_clear", d, 32'h0);
        for (int k = 0; k < 8; k++) begin
            btn[1] = pat[k][0];
            step();
        end
        idle(2);
        chk("bounce_led_before", {31'd0, led[1]}, 32'd0);
        step();
        chk("bounce_led_after", {31'd0, led[1]}, 32'd1);
        btn[1] = 1'b0;
        idle(8);
        wb_read(32'h8, d);
        chk("bounce_press", d, 32'h2);

        wb_write(32'h4, 32'h4);
        for (int p = 0; p < 3; p++) begin
            btn[2] = 1'b1;
            idle(8);
            chk("toggle_press", {31'd0, led[2]}, (p % 2 == 0) ? 32'd1 : 32'd0);
            btn[2] = 1'b0;
            idle(8);
            chk("toggle_release", {31'd0, led[2]}, (p % 2 == 0) ? 32'd1 : 32'd0);
        end

        wb_write(32'hC, 32'h8);
        wb_read(32'hC, d);
`ifdef BUTTON_CTRL_IRQ_EN
        chk("ien_read", d, 32'h8);
`else
        chk("ien_read", d, 32'h0);
`endif
        btn[3] = 1'b1;
        idle(8);
`ifdef BUTTON_CTRL_IRQ_EN
        chk("irq_set", {31'd0, irq}, 32'd1);
`else
        chk("irq_set", {31'd0, irq}, 32'd0);
`endif
        wb_write(32'h8, 32'h8);
        chk("irq_clear", {31'd0, irq}, 32'd0);
        btn[3] = 1'b0;
        idle(8);

        btn[0] = 1'b0;
        idle(10);
        wb_write(32'h8, 32'hF);
        btn[0] = 1'b1;
        idle(5);
        adr = 32'h8; wdat = 32'h1; sel = 4'h1; we = 1'b1; stb = 1'b1; cyc_i = 1'b1;
        step();
        stb = 1'b0; cyc_i = 1'b0; we = 1'b0;
        step();
        wb_read(32'h8, d);
        chk("set_wins", d, 32'h1);

        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) btn[i] = ~btn[i];
            if (stb) begin
                stb = 1'b0;
                cyc_i = 1'b0;
            end else if ($urandom_range(0, 6) == 0) begin
                adr = $urandom;
                wdat = $urandom;
                sel = 4'($urandom);
                we = 1'($urandom);
                cyc_i = $urandom_range(0, 3) != 0;
                stb = 1'b1;
            end
            step();
        end
        stb = 1'b0; cyc_i = 1'b0; we = 1'b0; btn = 4'h0;
        idle(10);

        wb_write(32'h4, 32'hF);
        wb_read(32'h4, d);
        chk("mode_all", d, 32'hF);
        adr = 32'h4; we = 1'b0; stb = 1'b1; cyc_i = 1'b1;
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_led", {28'd0, led}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        stb = 1'b0; cyc_i = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);
        wb_read(32'h4, d);
        chk("rst_mode", d, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
